// File: rtl/bit_stream_serializer_if.sv
// Handshake bundle for bit_stream_serializer: word input, serial output and FIFO status.
interface bit_stream_serializer_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
);
    logic                           flush;
    logic                           in_valid;
    logic                           in_ready;
    logic [WIDTH-1:0]               in_data;
    logic                           out_en;
    logic                           dout;
    logic                           dout_valid;
    logic [$clog2(DEPTH+1)-1:0]     fifo_count;

    modport master (
        output flush, in_valid, in_data, out_en,
        input  in_ready, dout, dout_valid, fifo_count
    );

    modport slave (
        input  flush, in_valid, in_data, out_en,
        output in_ready, dout, dout_valid, fifo_count
    );
endinterface

// File: rtl/bit_stream_serializer.sv
// Word FIFO feeding a parallel-to-serial shifter; gapless stream while words are queued.
// Define SERIALIZER_LSB_FIRST_EN to emit bit 0 of each word first (default MSB-first).
module bit_stream_serializer #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input logic                   clk,
    input logic                   reset,
    bit_stream_serializer_if.slave bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned BW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [BW-1:0]    bits_left_q, bits_left_d;

    logic             in_ready;
    logic             push;
    logic             load;
    logic [WIDTH-1:0] head;
    logic [WIDTH-1:0] head_ord;

    assign in_ready = (count_q < CW'(DEPTH));
    assign push     = bus.in_valid && in_ready && !bus.flush;
    // Reload on the last enabled bit keeps back-to-back words gapless.
    assign load     = (count_q != '0) && !bus.flush &&
                      ((bits_left_q == '0) || ((bits_left_q == BW'(1)) && bus.out_en));
    assign head     = mem_q[rd_ptr_q];

    always_comb begin
        head_ord = head;
`ifdef SERIALIZER_LSB_FIRST_EN
        for (int i = 0; i < int'(WIDTH); i++) begin
            head_ord[i] = head[WIDTH-1-i];
        end
`endif
    end

    always_comb begin
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        shreg_d     = shreg_q;
        bits_left_d = bits_left_q;

        if (bus.flush) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            shreg_d     = '0;
            bits_left_d = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = bus.in_data;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (load) begin
                rd_ptr_d    = rd_ptr_q + 1'b1;
                shreg_d     = head_ord;
                bits_left_d = BW'(WIDTH);
            end else if (bus.out_en && (bits_left_q > BW'(1))) begin
                shreg_d     = {shreg_q[WIDTH-2:0], 1'b0};
                bits_left_d = bits_left_q - 1'b1;
            end else if (bus.out_en && (bits_left_q == BW'(1))) begin
                shreg_d     = '0;
                bits_left_d = '0;
            end
            count_d = count_q + CW'(push) - CW'(load);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            shreg_q     <= '0;
            bits_left_q <= '0;
        end else begin
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            shreg_q     <= shreg_d;
            bits_left_q <= bits_left_d;
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.dout       = shreg_q[WIDTH-1];
    assign bus.dout_valid = (bits_left_q != '0);
    assign bus.fifo_count = count_q;
endmodule

// File: tb/tb_bit_stream_serializer.sv
// Scoreboard bench for bit_stream_serializer: a word/bit-queue model predicts the stream and
// status outputs; a negedge monitor compares them against the DUT every cycle.
module tb_bit_stream_serializer;
    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 4;

    logic clk = 1'b0;
    logic reset;

    bit_stream_serializer_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    bit_stream_serializer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    // Reference model: pending output bits in emission order, words waiting in the FIFO,
    // and bits still owed by the word currently being shifted out.
    bit exp_bits[$];
    int m_count = 0;
    int m_bits  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            exp_bits.delete();
            m_count = 0;
            m_bits  = 0;
        end else if (bus.flush) begin
            exp_bits.delete();
            m_count = 0;
            m_bits  = 0;
        end else begin
            bit do_load;
            bit do_push;
            if (bus.out_en && m_bits > 0 && exp_bits.size() > 0) void'(exp_bits.pop_front());
            do_load = (m_count > 0) && (m_bits == 0 || (m_bits == 1 && bus.out_en));
            do_push = bus.in_valid && (m_count < int'(DEPTH));
            if (do_load) m_bits = WIDTH;
            else if (bus.out_en && m_bits > 0) m_bits = m_bits - 1;
            m_count = m_count + int'(do_push) - int'(do_load);
            if (do_push) begin
                for (int i = 0; i < int'(WIDTH); i++) begin
`ifdef SERIALIZER_LSB_FIRST_EN
                    exp_bits.push_back(bus.in_data[i]);
`else
                    exp_bits.push_back(bus.in_data[WIDTH-1-i]);
`endif
                end
            end
        end
    end

    // Monitor: compare every cycle away from the active edge.
    always @(negedge clk) begin
        check("dout_valid", int'(bus.dout_valid), int'(m_bits != 0));
        check("fifo_count", int'(bus.fifo_count), m_count);
        check("in_ready", int'(bus.in_ready), int'(m_count < int'(DEPTH)));
        if (bus.dout_valid) begin
            if (exp_bits.size() == 0) check("dout_underflow", int'(bus.dout), -1);
            else check("dout_bit", int'(bus.dout), int'(exp_bits[0]));
        end else begin
            check("dout_idle", int'(bus.dout), 0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [WIDTH-1:0] w);
        bus.in_valid = 1'b1;
        bus.in_data  = w;
        step();
        bus.in_valid = 1'b0;
    endtask

    initial begin
        reset        = 1'b1;
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.out_en   = 1'b0;
        step();
        step();
        reset = 1'b0;
        repeat (10) step();

        // Single word, then back-to-back 0xFF/0x00.
        bus.out_en = 1'b1;
        push_word(8'hB4);
        repeat (10) step();
        push_word(8'hFF);
        push_word(8'h00);
        repeat (20) step();

        // Fill with out_en low; sixth word must stall.
        bus.out_en = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = WIDTH'($urandom);
            step();
        end
        check("full_count", int'(bus.fifo_count), int'(DEPTH));
        check("full_ready", int'(bus.in_ready), 0);
        bus.out_en = 1'b1;
        step();
        bus.in_valid = 1'b0;
        repeat (50) step();

        // Toggle out_en mid-word.
        push_word(8'h5C);
        for (int i = 0; i < 24; i++) begin
            bus.out_en = i[0];
            step();
        end
        bus.out_en = 1'b1;
        repeat (12) step();

        // Flush after three bits with two words queued; the flush-cycle push is dropped.
        push_word(8'hA7);
        push_word(8'h3C);
        push_word(8'hE1);
        step();
        bus.flush    = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h99;
        step();
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        check("flush_valid", int'(bus.dout_valid), 0);
        check("flush_count", int'(bus.fifo_count), 0);
        repeat (5) step();

        // Asynchronous reset mid-word.
        push_word(8'hC3);
        push_word(8'h81);
        step();
        step();
        #2 reset = 1'b1;
        #1;
        check("areset_valid", int'(bus.dout_valid), 0);
        check("areset_dout", int'(bus.dout), 0);
        check("areset_count", int'(bus.fifo_count), 0);
        step();
        reset = 1'b0;
        step();

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            bus.in_valid = ($urandom_range(0, 3) != 0);
            bus.in_data  = WIDTH'($urandom);
            bus.out_en   = ($urandom_range(0, 4) != 0);
            bus.flush    = ($urandom_range(0, 99) == 0);
            step();
        end
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
        bus.out_en   = 1'b1;
        repeat (60) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
